seg_display_mux: RTL and testbench
==================================

// Module: seg_display_mux
// PURPOSE
//  Parametrised multiplexed 7-segment display driver for the Nexys7 board.
//  - Accepts a signed two's-complement binary value and converts it to BCD with a sequential double-dabble unit.
//  - Scans N_DIGITS common-anode digits with leading-zero blanking, a sign digit, overflow indication and PWM brightness.
//  - Sits between the datapath result register and the board segment/anode pins.
// PARAMETERS
//  N_DIGITS     8        physical digits; N_BCD = N_DIGITS-1 carry magnitude, one is reserved for sign
//  VAL_W        16       width of signed input value
//  REFRESH_DIV  100_000  clk cycles per digit slot; must be a multiple of 2**BRIGHT_W
//  BRIGHT_W     3        brightness control width
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous active-low reset
//  value        in   VAL_W     signed value to display
//  load         in   1         capture request; accepted only when busy==0
//  busy         out  1         conversion in progress
//  blank_lz     in   1         1 = blank leading zeros and float the sign
//  brightness   in   BRIGHT_W  duty level 0..2**BRIGHT_W-1
//  digit_anode  out  N_DIGITS  active-low digit enable; bit 0 = rightmost digit
//  segment      out  8         active-low segments {dp,g,f,e,d,c,b,a}; dp always off
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - Outputs: digit_anode all 1, segment 8'hFF, busy 0.
//    - Internal: FSM IDLE, scan index 0, scan counter 0.
//    - Display register = value 0, sign 0, overflow 0.
//  - Reset mid-conversion aborts it; the display returns to "0".
//  - Conversion FSM, states IDLE -> CONV -> COMMIT -> IDLE:
//    - IDLE: load=1 captures sign=value[MSB] and mag=|value| (VAL_W bits unsigned; -2**(VAL_W-1) is representable).
//    - CONV: lasts exactly VAL_W cycles, one double-dabble shift per cycle (add 3 to each nibble >=5, then shift).
//      Any 1 shifted out of the top of the N_BCD*4 register sets a sticky overflow flag.
//    - COMMIT: one cycle; BCD digits, sign and overflow are written atomically to the display register.
//    - busy = 1 in CONV and COMMIT. Latency is load edge -> new display data after VAL_W+1 cycles.
//    - load while busy is ignored (not queued); the display never shows a partial result.
//  - Scan:
//    - Counter runs 0..REFRESH_DIV-1; on wrap the scan index advances modulo N_DIGITS (N_DIGITS-1 -> 0).
//    - Exactly one anode bit can be low at any time.
//    - The anode of the current index is low only while counter < (brightness+1)*(REFRESH_DIV>>BRIGHT_W).
//      The maximum brightness code gives 100% duty; code 0 gives 1/2**BRIGHT_W.
//    - segment and digit_anode are registered, one cycle after the scan counter/index.
//  - Digit content for index i:
//    - overflow=1: every digit shows 8'h8E ("F"); sign is ignored.
//    - i < N_BCD: BCD nibble i. It is blank (8'hFF) when blank_lz=1 and i > msd, where msd is the highest nonzero nibble (0 if the value is 0).
//    - Sign: minus (8'hBF) at index msd+1 when blank_lz=1, else at index N_DIGITS-1. Blank if sign=0.
//    - Value 0 always shows "0" at index 0 with no minus (-0 cannot occur).
//  - Codes (active low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, minus BF, blank FF, F 8E.
//  - Simultaneous events:
//    - load in the COMMIT cycle is ignored.
//    - A scan wrap coinciding with COMMIT shows the new data in the new slot.
// STRUCTURE
//  - Shared package seg_pkg: SEG_* localparam codes (digits 0-9, SEG_MINUS, SEG_BLANK, SEG_OVF), typedef seg_code_t (logic [7:0]), function bcd_to_seg().
//  - Sub-module bin_to_bcd_seq (VAL_W, N_BCD): start/busy/done handshake, bcd out, ovf out.
//  - Top level holds the conversion FSM, the display register, the scan/PWM counters and the digit-select mux.
// TESTING  (N_DIGITS=4, VAL_W=12, REFRESH_DIV=8, BRIGHT_W=3)
//  1 Reset held 3 cycles, then released -> anode 4'hF / seg FF during reset; afterwards digit0 = C0, digits 1-3 FF (blank_lz=1).
//  2 load 123, blank_lz=1 -> busy for 13 cycles; digits 0..3 = B0, A4, F9, FF.
//  3 load -45: blank_lz=1 -> digits 92, 99, BF, FF; blank_lz=0 -> 92, 99, C0, BF.
//  4 load 1000, then load -2048 -> every digit 8E both times; load 999 -> 90, 90, 90, FF.
//  5 load 7 then load 5 two cycles later -> second load ignored; display stays old until COMMIT, then 7 only.
//  6 brightness=0 -> each anode low 1 of 8 cycles; brightness=7 -> 8 of 8, never two anodes low.
//    Assert rst_n mid-CONV -> busy 0 and display "0".

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Active-low 7-segment codes, digit decoder and conversion FSM
//               states shared by the display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  typedef logic [7:0] seg_code_t;

  // Bit order {dp,g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam seg_code_t SEG_0     = 8'hC0;
  localparam seg_code_t SEG_1     = 8'hF9;
  localparam seg_code_t SEG_2     = 8'hA4;
  localparam seg_code_t SEG_3     = 8'hB0;
  localparam seg_code_t SEG_4     = 8'h99;
  localparam seg_code_t SEG_5     = 8'h92;
  localparam seg_code_t SEG_6     = 8'h82;
  localparam seg_code_t SEG_7     = 8'hF8;
  localparam seg_code_t SEG_8     = 8'h80;
  localparam seg_code_t SEG_9     = 8'h90;
  localparam seg_code_t SEG_MINUS = 8'hBF;
  localparam seg_code_t SEG_BLANK = 8'hFF;
  localparam seg_code_t SEG_OVF   = 8'h8E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic seg_code_t bcd_to_seg(input logic [3:0] nib);
    seg_code_t code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential double-dabble converter, one shift per cycle, with
//               sticky overflow when the magnitude exceeds N_BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int VAL_W = 16,
  parameter int N_BCD = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [VAL_W-1:0]   bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_BCD*4-1:0] bcd_o,
  output logic               ovf_o
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   sh_q, sh_d;
  logic [N_BCD*4-1:0] bcd_q, bcd_d, adj;
  logic               ovf_q, ovf_d;

  for (genvar n = 0; n < N_BCD; n++) begin : g_adj
    assign adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3
                                                      : bcd_q[n*4 +: 4];
  end

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (cnt_q != '0) begin
      {bcd_d, sh_d} = {adj[N_BCD*4-2:0], sh_q, 1'b0};
      ovf_d         = ovf_q | adj[N_BCD*4-1];
      cnt_d         = cnt_q - CNT_W'(1);
    end else if (start_i) begin
      cnt_d = CNT_W'(VAL_W);
      sh_d  = bin_i;
      bcd_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_mux
// Description : Signed value to multiplexed common-anode 7-segment display with
//               leading-zero blanking, sign digit, overflow and PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int VAL_W       = 16,
  parameter int REFRESH_DIV = 100_000,
  parameter int BRIGHT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VAL_W-1:0]    value,
  input  logic                load,
  output logic                busy,
  input  logic                blank_lz,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [N_DIGITS-1:0] digit_anode,
  output logic [7:0]          segment
);

  localparam int N_BCD     = N_DIGITS - 1;
  localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SCAN_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DUTY_STEP = REFRESH_DIV >> BRIGHT_W;

  conv_state_e        state_q, state_d;
  logic               start, commit;
  logic               conv_busy, conv_done, conv_ovf;
  logic [N_BCD*4-1:0] conv_bcd;
  logic [VAL_W-1:0]   mag;
  logic               sign_q;

  logic [N_BCD*4-1:0] disp_bcd_q;
  logic               disp_sign_q, disp_ovf_q;

  logic [SCAN_W-1:0]   scan_cnt_q;
  logic [IDX_W-1:0]    scan_idx_q;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  seg_code_t           seg_q, seg_d;

  assign mag = value[VAL_W-1] ? (~value + VAL_W'(1)) : value;

  bin_to_bcd_seq #(
    .VAL_W (VAL_W),
    .N_BCD (N_BCD)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (mag),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          start   = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done || !conv_busy) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      disp_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) sign_q <= value[VAL_W-1];
      if (commit) begin
        disp_bcd_q  <= conv_bcd;
        disp_sign_q <= sign_q;
        disp_ovf_q  <= conv_ovf;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  logic [N_DIGITS*4-1:0] nibs;
  logic [3:0]            nib;
  logic [IDX_W-1:0]      msd, sign_pos;
  logic [31:0]           duty_lim;

  always_comb begin
    nibs = {4'h0, disp_bcd_q};
    nib  = nibs[{scan_idx_q, 2'b00} +: 4];
    msd  = '0;
    for (int k = 0; k < N_BCD; k++) begin
      if (disp_bcd_q[k*4 +: 4] != 4'd0) msd = IDX_W'(k);
    end
    // With blanking the minus floats just left of the most significant digit.
    sign_pos = blank_lz ? (msd + IDX_W'(1)) : IDX_W'(N_DIGITS - 1);

    if (disp_ovf_q)                                     seg_d = SEG_OVF;
    else if (disp_sign_q && (scan_idx_q == sign_pos))   seg_d = SEG_MINUS;
    else if (scan_idx_q >= IDX_W'(N_BCD))               seg_d = SEG_BLANK;
    else if (blank_lz && (scan_idx_q > msd))            seg_d = SEG_BLANK;
    else                                                seg_d = bcd_to_seg(nib);

    duty_lim = (32'(brightness) + 32'd1) * 32'(DUTY_STEP);
    anode_d  = '1;
    if (32'(scan_cnt_q) < duty_lim) anode_d[scan_idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign digit_anode = anode_q;
  assign segment     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_mux
// Description : Directed bench for seg_display_mux with a text-rendering model
//               of the expected display checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_mux;

  localparam int ND = 4;
  localparam int VW = 12;
  localparam int RD = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          busy;
  logic          blank_lz = 1'b1;
  logic [BW-1:0] brightness = 3'd7;
  logic [ND-1:0] digit_anode;
  logic [7:0]    segment;

  int vectors = 0;
  int miscompares = 0;

  seg_display_mux #(
    .N_DIGITS    (ND),
    .VAL_W       (VW),
    .REFRESH_DIV (RD),
    .BRIGHT_W    (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .busy        (busy),
    .blank_lz    (blank_lz),
    .brightness  (brightness),
    .digit_anode (digit_anode),
    .segment     (segment)
  );

  always #5 clk = ~clk;

  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Render the value as the text a reader would expect, then pick the glyph.
  function automatic logic [7:0] exp_code(input int v, input bit blz, input int i);
    int    mag;
    string s;
    byte   ch;
    mag = (v < 0) ? -v : v;
    if (mag > 999) return 8'h8E;
    if (blz) s = (v < 0) ? $sformatf("-%0d", mag) : $sformatf("%0d", mag);
    else     s = (v < 0) ? $sformatf("-%03d", mag) : $sformatf(" %03d", mag);
    if (i >= s.len()) return 8'hFF;
    ch = s[s.len() - 1 - i];
    if (ch >= "0" && ch <= "9") return lut[ch - "0"];
    if (ch == "-") return 8'hBF;
    return 8'hFF;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: edges since reset release, accepted load edge, shown value.
  int         e = 0, acc = -1000, disp_v = 0, pend_v = 0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_seg = 8'hFF;
  logic       exp_busy = 1'b0;

  initial begin : model
    int pos, s_cnt, s_idx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; acc = -1000; disp_v = 0;
        exp_an = 4'hF; exp_seg = 8'hFF; exp_busy = 1'b0;
      end else begin
        e++;
        pos    = e - 1;
        s_cnt  = pos % RD;
        s_idx  = (pos / RD) % ND;
        exp_an = (s_cnt < (int'(brightness) + 1) * (RD >> BW)) ? ~(4'b0001 << s_idx) : 4'hF;
        exp_seg = exp_code(disp_v, blank_lz, s_idx);
        if (e == acc + VW + 1) disp_v = pend_v;
        if (load && !(e >= acc + 1 && e <= acc + VW + 1)) begin
          acc    = e;
          pend_v = int'($signed(value));
        end
        exp_busy = (e >= acc && e <= acc + VW);
      end
    end
  end

  logic chk_en = 1'b0;
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("anode", int'(digit_anode), int'(exp_an));
        check("segment", int'(segment), int'(exp_seg));
        check("busy", int'(busy), int'(exp_busy));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    value = VW'(v);
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  // Hand-computed glyphs, captured while each digit is the one lit.
  task automatic check_digits(input string name, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] want [4];
    logic [3:0] pat;
    bit         seen;
    want = '{d0, d1, d2, d3};
    for (int i = 0; i < ND; i++) begin
      pat  = ~(4'b0001 << i);
      seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
        @(negedge clk);
        if (digit_anode == pat) begin
          seen = 1'b1;
          check($sformatf("%s_d%0d", name, i), int'(segment), int'(want[i]));
        end
      end
      if (!seen) check($sformatf("%s_d%0d_timeout", name, i), 0, 1);
    end
    tick(1);
  endtask

  task automatic count_lit(input string name, input int want);
    int n = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if ($countones(~digit_anode) == 1) n++;
    end
    check(name, n, want);
    tick(1);
  endtask

  initial begin : stim
    int nb;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    rst_n = 1'b1;
    check_digits("reset", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    value = VW'(123);
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    nb    = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      else if (nb > 0) break;
    end
    check("busy_len", nb, 13);
    tick(2);
    check_digits("v123", 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    do_load(-45);
    tick(16);
    check_digits("m45_blz", 8'h92, 8'h99, 8'hBF, 8'hFF);
    blank_lz = 1'b0;
    tick(2);
    check_digits("m45_pad", 8'h92, 8'h99, 8'hC0, 8'hBF);
    blank_lz = 1'b1;

    do_load(1000);
    tick(16);
    check_digits("v1000", 8'h8E, 8'h8E, 8'h8E, 8'h8E);
    do_load(-2048);
    tick(16);
    check_digits("m2048", 8'h8E, 8'h8E, 8'h8E, 8'h8E);
    do_load(999);
    tick(16);
    check_digits("v999", 8'h90, 8'h90, 8'h90, 8'hFF);

    do_load(7);
    tick(1);
    do_load(5);
    tick(16);
    check_digits("v7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);

    brightness = 3'd0;
    tick(2);
    count_lit("duty_min", 4);
    brightness = 3'd7;
    tick(2);
    count_lit("duty_max", 32);

    do_load(321);
    tick(5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_anode", int'(digit_anode), 4'hF);
    tick(2);
    rst_n = 1'b1;
    check_digits("after_rst", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    tick(3);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
